// File: rtl/uart_tx_buf.sv
// uart_tx_buf: 8N1 UART transmitter with a small input byte FIFO.
//
// Bytes arrive as single-cycle strobes (tx_data/tx_en) and are queued in a
// DEPTH-entry FIFO. A four-state framer (IDLE/START/DATA/STOP) pops the head
// and shifts it out LSB first, each bit held BIT_CYCLES = CLK_FREQ/BAUD cycles.
// When another byte is queued at the end of a stop bit, the next start bit
// follows with no idle gap.
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   [7:0] byte to send, sampled when tx_en=1
//   tx_en     in   one-cycle write strobe
//   tx        out  serial line, idle high, driven from a flop
//   busy      out  frame on the line or FIFO non-empty
//   fifo_full out  FIFO holds DEPTH bytes
//   overflow  out  one-cycle pulse after a write was dropped
module uart_tx_buf #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 8
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(BIT_CYCLES);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]     mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  count_s;
  state_t         state_r;
  state_t         state_s;
  logic [BCW-1:0] baud_r;
  logic [BCW-1:0] baud_s;
  logic [2:0]     bit_idx_r;
  logic [2:0]     bit_idx_s;
  logic [7:0]     sh_r;
  logic           tx_r;
  logic           busy_r;
  logic           fifo_full_r;
  logic           overflow_r;

  logic           full_s;
  logic           push_s;
  logic           pop_s;
  logic           baud_last_s;
  logic           tx_s;
  logic           busy_s;
  logic           full_next_s;
  logic           overflow_s;

  // FIFO handshake: fullness is judged on the pre-edge occupancy, so a write
  // while full is dropped even if the framer pops in the same cycle.
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    push_s      = tx_en & ~full_s;
    overflow_s  = tx_en & full_s;
    baud_last_s = (baud_r == BAUD_LAST);
  end

  // Framer next-state, pop request and next line level.
  always_comb begin
    state_s   = state_r;
    bit_idx_s = bit_idx_r;
    pop_s     = 1'b0;
    tx_s      = 1'b1;
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (count_r != CW'(0)) begin
          pop_s   = 1'b1;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_s = 1'b0;
        if (baud_last_s) begin
          state_s   = DATA;
          bit_idx_s = 3'd0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        tx_s = sh_r[bit_idx_r];
        if (baud_last_s) begin
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (baud_last_s) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (count_r != CW'(0)) begin
            pop_s   = 1'b1;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        tx_s    = 1'b1;
      end
    endcase
  end

  // Baud counter: every state entry happens on a bit boundary or from IDLE,
  // so clearing on those two conditions restarts it at each entry.
  always_comb begin
    if (state_r == IDLE) begin
      baud_s = BCW'(0);
    end else if (baud_last_s) begin
      baud_s = BCW'(0);
    end else begin
      baud_s = baud_r + BCW'(1);
    end
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
    busy_s      = (state_s != IDLE) || (count_s != CW'(0));
    full_next_s = (count_s == FULL_CNT);
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // Control state, pointers, shift register and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      baud_r      <= BCW'(0);
      bit_idx_r   <= 3'd0;
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      count_r     <= CW'(0);
      sh_r        <= 8'd0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      fifo_full_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      baud_r      <= baud_s;
      bit_idx_r   <= bit_idx_s;
      count_r     <= count_s;
      tx_r        <= tx_s;
      busy_r      <= busy_s;
      fifo_full_r <= full_next_s;
      overflow_r  <= overflow_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        sh_r     <= mem_r[rd_ptr_r];
      end
    end
  end

  assign tx        = tx_r;
  assign busy      = busy_r;
  assign fifo_full = fifo_full_r;
  assign overflow  = overflow_r;

endmodule
